imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the LEGv8 datapath. Takes the low 26 instruction bits and
//  a format select; produces the extended/shifted immediate for ALU-B, branch-target and move-wide paths.
//  Adds MOVZ (16-bit imm, LSL 16*hw), valid/ready flow control, per-item error flag and a saturating error counter.
// PARAMETERS
//  DATA_W     64  output width; legal values 32 or 64 only
//  STAGES     2   pipeline depth; legal values 1 or 2 (STAGES=1: decode+extend in one register stage)
//  ERR_CNT_W  8   width of saturating error counter
// PORTS
//  CLK        in   1        clock; all state on rising edge
//  resetl     in   1        asynchronous, active-low reset
//  in_valid   in   1        Imm26/Ctrl valid
//  in_ready   out  1        pipe can accept this cycle
//  Imm26      in   26       instruction bits [25:0]
//  Ctrl       in   3        format select (codes in package)
//  out_valid  out  1        BusImm/out_err valid
//  out_ready  in   1        consumer accepts this cycle
//  BusImm     out  DATA_W   extended immediate
//  out_err    out  1        item used reserved Ctrl or an unrepresentable MOVZ shift
//  err_clr    in   1        synchronous clear of err_count
//  err_count  out  ERR_CNT_W  number of errored items delivered, saturating
// BEHAVIOUR
//  Formats (S = sign-extend to DATA_W, Z = zero-extend):
//   000 I-type : Z(Imm26[21:10])              001 D-type: S(Imm26[20:12])
//   010 B      : S({Imm26[25:0],2'b00})       011 CBZ   : S({Imm26[23:5],2'b00})
//   100 MOVZ   : Z(Imm26[20:5]) << (16*Imm26[22:21])
//   101,110,111: reserved -> BusImm=0, out_err=1
//  DATA_W=32, MOVZ with hw>=2: BusImm=0, out_err=1. All other cases out_err=0.
//  Handshake: transfer on valid&&ready at either side. Stage k holds {valid,data,err}; stage k loads when it is
//   empty or its content moves on the same cycle (ready_k = !valid_k || ready_{k+1}; ready_{STAGES} = out_ready).
//  in_ready = ready_0, combinational; never depends on in_valid. Full throughput: 1 item/cycle with out_ready=1.
//  Latency: item accepted in cycle t appears as out_valid in cycle t+STAGES.
//  Stall: out_valid && !out_ready -> BusImm/out_err held stable, out_valid stays 1 until accepted.
//  Ordering: strictly FIFO; no item dropped or duplicated; pipe holds at most STAGES items.
//  STAGES=2 split: stage 0 registers extracted field, sign bit, shift amount, err; stage 1 registers extended result.
//  err_count: +1 on out_valid&&out_ready&&out_err; saturates at all-ones; err_clr same cycle takes priority (->0).
//  Reset (async, resetl=0): all stage valids=0, data=0, out_valid=0, BusImm=0, out_err=0, err_count=0;
//   in_ready=1 combinationally once valids clear. Reset mid-stream discards in-flight items; none emitted after.
//  Input fields outside the selected format are don't-care; X on them must not reach BusImm.
// STRUCTURE
//  Package imm_ext_pkg: Ctrl code localparams (IMM_I, IMM_D, IMM_B, IMM_CBZ, IMM_MOVZ), CTRL_W=3,
//   hw shift unit (16); localparam checks of DATA_W/STAGES raise an elaboration error if illegal.
//  Sub-module imm_ext_stage: one valid/data/err register slot with ready chaining, DATA_W-parametrised;
//   instantiated STAGES times via generate. Extraction/extension logic stays in the top.
// TESTING
//  1 Ctrl=000, Imm26[21:10]=12'hFFF, out_ready=1 -> BusImm=64'h0000_0000_0000_0FFF, out_err=0, 2 cycles later.
//  2 Ctrl=001 Imm26[20:12]=9'h100 -> 64'hFFFF_FFFF_FFFF_FF00; Ctrl=010 Imm26=26'h3FFFFFF -> 64'hFFFF_FFFF_FFFF_FFFC;
//    Ctrl=011 Imm26[23:5]=19'h00001 -> 64'h0000_0000_0000_0004.
//  3 Ctrl=100, Imm26[22:21]=2'b10, Imm26[20:5]=16'hBEEF -> 64'h0000_BEEF_0000_0000; DATA_W=32 same -> 0, out_err=1.
//  4 Back-to-back 10 items, out_ready low cycles 3-5 -> in_ready drops once 2 items held, outputs stable,
//    all 10 emitted in order, no loss/duplicate.
//  5 Ctrl=111 x300 with ERR_CNT_W=8 -> err_count saturates 255; err_clr coincident with errored transfer -> 0.
//  6 resetl low mid-stream with 2 items in flight -> out_valid=0 immediately, err_count=0, nothing emitted later.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the LEGv8 immediate generator: Ctrl codes, the
// pre-extension record carried between pipeline stages, and the field decoder.
package imm_ext_pkg;

  localparam int CTRL_W   = 3;
  localparam int HW_SHIFT = 16;
  localparam int FIELD_W  = 28;
  localparam int SHAMT_W  = 6;

  localparam logic [CTRL_W-1:0] IMM_I    = 3'b000;
  localparam logic [CTRL_W-1:0] IMM_D    = 3'b001;
  localparam logic [CTRL_W-1:0] IMM_B    = 3'b010;
  localparam logic [CTRL_W-1:0] IMM_CBZ  = 3'b011;
  localparam logic [CTRL_W-1:0] IMM_MOVZ = 3'b100;

  // field is already sign/zero-extended to FIELD_W; the final stage widens it
  // to DATA_W with sign and applies the move-wide shift.
  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic               sign;
    logic [SHAMT_W-1:0] shamt;
  } pre_t;

  localparam int PRE_W = $bits(pre_t);

  typedef struct packed {
    pre_t pre;
    logic err;
  } dec_t;

  function automatic bit cfg_legal(input int data_w, input int stages);
    return ((data_w == 32) || (data_w == 64)) && ((stages == 1) || (stages == 2));
  endfunction

  function automatic dec_t pre_decode(input logic [25:0] imm, input logic [CTRL_W-1:0] ctrl,
                                      input bit narrow);
    dec_t d;
    d = '0;
    case (ctrl)
      IMM_I:   d.pre.field = {16'b0, imm[21:10]};
      IMM_D: begin
        d.pre.field = {{19{imm[20]}}, imm[20:12]};
        d.pre.sign  = imm[20];
      end
      IMM_B: begin
        d.pre.field = {imm, 2'b00};
        d.pre.sign  = imm[25];
      end
      IMM_CBZ: begin
        d.pre.field = {{7{imm[23]}}, imm[23:5], 2'b00};
        d.pre.sign  = imm[23];
      end
      IMM_MOVZ: begin
        // a 32-bit result cannot hold hw=2/3, flag it instead of truncating
        if (narrow && imm[22]) begin
          d.err = 1'b1;
        end else begin
          d.pre.field = {12'b0, imm[20:5]};
          d.pre.shamt = SHAMT_W'(HW_SHIFT * int'(imm[22:21]));
        end
      end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_ext_stage.sv
// One valid/data/err pipeline slot; accepts when empty or when its content
// leaves on the same cycle.
module imm_ext_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  // payload only captured on a real transfer so idle inputs never reach the slot
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        err_d  = in_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined LEGv8 immediate generator with valid/ready flow control, per-item
// error flag and a saturating count of errored items delivered.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int STAGES    = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [25:0]          Imm26,
  input  logic [CTRL_W-1:0]    Ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    BusImm,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (!cfg_legal(DATA_W, STAGES)) begin : g_bad_cfg
    $error("imm_extend_pipe: DATA_W must be 32 or 64 and STAGES 1 or 2");
  end

  function automatic logic [DATA_W-1:0] extend(input pre_t p);
    logic [DATA_W-1:0] w;
    w = {{(DATA_W-FIELD_W){p.sign}}, p.field};
    return w << p.shamt;
  endfunction

  dec_t dec;
  always_comb dec = pre_decode(Imm26, Ctrl, DATA_W == 32);

  if (STAGES == 1) begin : g_one
    logic [DATA_W-1:0] ext;
    always_comb ext = extend(dec.pre);

    imm_ext_stage #(.DATA_W(DATA_W)) u_s0 (
      .clk(CLK), .rst_n(resetl),
      .in_valid(in_valid), .in_data(ext), .in_err(dec.err),
      .out_ready(out_ready), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(BusImm), .out_err(out_err)
    );
  end else begin : g_two
    logic              s0_valid, s0_err, s1_ready;
    logic [PRE_W-1:0]  s0_data;
    pre_t              s0_pre;
    logic [DATA_W-1:0] ext;

    imm_ext_stage #(.DATA_W(PRE_W)) u_s0 (
      .clk(CLK), .rst_n(resetl),
      .in_valid(in_valid), .in_data(dec.pre), .in_err(dec.err),
      .out_ready(s1_ready), .in_ready(in_ready),
      .out_valid(s0_valid), .out_data(s0_data), .out_err(s0_err)
    );

    always_comb begin
      s0_pre = s0_data;
      ext    = extend(s0_pre);
    end

    imm_ext_stage #(.DATA_W(DATA_W)) u_s1 (
      .clk(CLK), .rst_n(resetl),
      .in_valid(s0_valid), .in_data(ext), .in_err(s0_err),
      .out_ready(out_ready), .in_ready(s1_ready),
      .out_valid(out_valid), .out_data(BusImm), .out_err(out_err)
    );
  end

  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (out_valid && out_ready && out_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) err_count_q <= '0;
    else         err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;

endmodule
